// File: rtl/capture_frame_ctrl_if.sv
// Frame-buffer write port: valid/ready handshake carrying a linear pixel address and RGB565 data.
// The capture controller is the master; the BRAM writer (or a bench) is the slave.
interface capture_frame_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              wr_valid_out;
    logic              wr_ready_in;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [15:0]       wr_data_out;

    modport master (
        output wr_valid_out,
        output wr_addr_out,
        output wr_data_out,
        input  wr_ready_in
    );

    modport slave (
        input  wr_valid_out,
        input  wr_addr_out,
        input  wr_data_out,
        output wr_ready_in
    );
endinterface

// File: rtl/capture_frame_ctrl.sv
// Frame capture sequencer: arms on command, aligns to frame start, optionally decimates,
// and feeds linear-addressed pixels into a one-entry valid/ready write register.
module capture_frame_ctrl #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int H_FIRST    = 1,
    parameter int DECIM_LOG2 = 0,
    parameter int ADDR_W     = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  arm_in,
    input  logic                  continuous_in,
    input  logic                  abort_in,
    input  logic                  valid_in,
    input  logic [15:0]           data_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    capture_frame_ctrl_if.master  wr_if,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic [15:0]           frame_count_out,
    output logic                  overflow_out,
    output logic                  short_frame_out
);

    localparam int               NPIX     = (H_ACTIVE >> DECIM_LOG2) * (V_ACTIVE >> DECIM_LOG2);
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] NPIX_C   = CNT_W'(NPIX);
    localparam logic [10:0]      H_FIRST_C  = 11'(H_FIRST);
    localparam logic [10:0]      H_ACTIVE_C = 11'(H_ACTIVE);
    localparam logic [10:0]      V_ACTIVE_C = 11'(V_ACTIVE);
    localparam logic [10:0]      DMASK_H  = 11'((1 << DECIM_LOG2) - 1);
    localparam logic [9:0]       DMASK_V  = 10'((1 << DECIM_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        data_q, data_d;
    logic               done_q, done_d;
    logic [15:0]        fcount_q, fcount_d;
    logic               ovf_q, ovf_d;
    logic               short_q, short_d;

    logic [10:0]        h_rel;
    logic               sof;
    logic               keep;
    logic               accept;
    logic               take;
    logic [CNT_W-1:0]   pix_addr;
    logic [CNT_W-1:0]   next_cnt;

    // Columns left of H_FIRST wrap to large values and fall outside the active window.
    assign h_rel  = hcount_in - H_FIRST_C;
    assign sof    = valid_in && (vcount_in == 10'd0) && (hcount_in == H_FIRST_C);
    assign keep   = valid_in
                 && (h_rel < H_ACTIVE_C)
                 && ({1'b0, vcount_in} < V_ACTIVE_C)
                 && ((h_rel & DMASK_H) == 11'd0)
                 && ((vcount_in & DMASK_V) == 10'd0);
    assign accept = full_q && wr_if.wr_ready_in;

    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        full_d   = full_q && !accept;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        fcount_d = fcount_q;
        ovf_d    = ovf_q;
        short_d  = short_q;
        take     = 1'b0;
        pix_addr = cnt_q;

        if (abort_in) begin
            state_d = S_IDLE;
            full_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm_in) begin
                        state_d = S_ARMED;
                        ovf_d   = 1'b0;
                        short_d = 1'b0;
                    end
                end
                S_ARMED: begin
                    // The frame-start pixel itself is the first captured pixel.
                    if (sof) begin
                        state_d  = S_CAPTURE;
                        pix_addr = '0;
                        take     = keep;
                    end
                end
                S_CAPTURE: begin
                    if (sof && (cnt_q != '0)) begin
                        short_d = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        take = keep;
                    end
                end
                S_DRAIN: begin
                    if (!full_q) begin
                        done_d   = 1'b1;
                        fcount_d = fcount_q + 16'd1;
                        state_d  = continuous_in ? S_ARMED : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        next_cnt = pix_addr + CNT_W'(1);
        if (take) begin
            // A dropped pixel still consumes its address so the frame geometry stays intact.
            cnt_d = next_cnt;
            if (!full_q || accept) begin
                full_d = 1'b1;
                addr_d = pix_addr[ADDR_W-1:0];
                data_d = data_in;
            end else begin
                ovf_d = 1'b1;
            end
            if (next_cnt == NPIX_C) begin
                state_d = S_DRAIN;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments only, so every register samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            // NOTE: the output address/data register is reset too because it drives ports
            // that must read zero while in reset; it is a single entry, not a memory array.
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            fcount_q <= '0;
            ovf_q    <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            fcount_q <= fcount_d;
            ovf_q    <= ovf_d;
            short_q  <= short_d;
        end
    end

    assign wr_if.wr_valid_out = full_q;
    assign wr_if.wr_addr_out  = addr_q;
    assign wr_if.wr_data_out  = data_q;
    assign busy_out           = (state_q != S_IDLE);
    assign frame_done_out     = done_q;
    assign frame_count_out    = fcount_q;
    assign overflow_out       = ovf_q;
    assign short_frame_out    = short_q;

endmodule

// File: tb/tb_capture_frame_ctrl.sv
// Directed bench for capture_frame_ctrl on an 8x4 frame: one full-rate instance and one
// instance decimating by 2 share the same pixel stream and control inputs.
module tb_capture_frame_ctrl;

    localparam int H_ACT = 8;
    localparam int V_ACT = 4;
    localparam int H_FST = 1;
    localparam int AW    = 6;

    logic        clk_in        = 1'b0;
    logic        rst_n_in      = 1'b1;
    logic        arm_in        = 1'b0;
    logic        continuous_in = 1'b0;
    logic        abort_in      = 1'b0;
    logic        valid_in      = 1'b0;
    logic [15:0] data_in       = '0;
    logic [10:0] hcount_in     = '0;
    logic [9:0]  vcount_in     = '0;

    logic        busy, done, ovf, shortf;
    logic [15:0] fcnt;
    logic        busy_d, done_d, ovf_d, shortf_d;
    logic [15:0] fcnt_d;

    capture_frame_ctrl_if #(.ADDR_W(AW)) wr_if ();
    capture_frame_ctrl_if #(.ADDR_W(AW)) wr_if_d ();

    capture_frame_ctrl #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_FIRST(H_FST), .DECIM_LOG2(0), .ADDR_W(AW)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .arm_in(arm_in), .continuous_in(continuous_in),
        .abort_in(abort_in), .valid_in(valid_in), .data_in(data_in), .hcount_in(hcount_in),
        .vcount_in(vcount_in), .wr_if(wr_if), .busy_out(busy), .frame_done_out(done),
        .frame_count_out(fcnt), .overflow_out(ovf), .short_frame_out(shortf)
    );

    capture_frame_ctrl #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_FIRST(H_FST), .DECIM_LOG2(1), .ADDR_W(AW)
    ) dut_d (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .arm_in(arm_in), .continuous_in(continuous_in),
        .abort_in(abort_in), .valid_in(valid_in), .data_in(data_in), .hcount_in(hcount_in),
        .vcount_in(vcount_in), .wr_if(wr_if_d), .busy_out(busy_d), .frame_done_out(done_d),
        .frame_count_out(fcnt_d), .overflow_out(ovf_d), .short_frame_out(shortf_d)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t wq[$];
    wr_t wq_d[$];
    int  done_cnt   = 0;
    int  done_cnt_d = 0;
    int  n_tests    = 0;
    int  n_fail     = 0;

    // Handshakes and done pulses are recorded on the falling edge, mid-cycle.
    always @(negedge clk_in) begin
        if (wr_if.wr_valid_out && wr_if.wr_ready_in)
            wq.push_back({wr_if.wr_addr_out, wr_if.wr_data_out});
        if (wr_if_d.wr_valid_out && wr_if_d.wr_ready_in)
            wq_d.push_back({wr_if_d.wr_addr_out, wr_if_d.wr_data_out});
        if (done)   done_cnt++;
        if (done_d) done_cnt_d++;
    end

    function automatic logic [15:0] pix_data(int h, int v);
        return {8'(v), 8'(h)};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_ready(logic r);
        wr_if.wr_ready_in   = r;
        wr_if_d.wr_ready_in = r;
    endtask

    task automatic drive_pix(int h, int v);
        valid_in  = 1'b1;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        data_in   = pix_data(h, v);
        tick();
        valid_in  = 1'b0;
    endtask

    task automatic idle(int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_arm();
        arm_in = 1'b1;
        tick();
        arm_in = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
    endtask

    task automatic do_reset();
        arm_in = 1'b0; abort_in = 1'b0; continuous_in = 1'b0; valid_in = 1'b0;
        set_ready(1'b1);
        rst_n_in = 1'b0;
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
    endtask

    // Raster of lines 0..V_ACT-1, columns 0..H_ACT+1 (one blanking column each side).
    task automatic drive_frame(int skip);
        for (int v = 0; v < V_ACT; v++)
            for (int h = 0; h < H_ACT + 2; h++)
                if (v * (H_ACT + 2) + h >= skip) drive_pix(h, v);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({busy, wr_if.wr_valid_out, fcnt, ovf, shortf, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b valid=%b fcnt=%0d ovf=%b short=%b done=%b, expected all 0",
                     busy, wr_if.wr_valid_out, fcnt, ovf, shortf, done);
        end
        set_ready(1'b0);
        pulse_arm();
        drive_pix(1, 0);
        n_tests++;
        if (wr_if.wr_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_valid: got %b expected 1", wr_if.wr_valid_out);
        end
        #2 rst_n_in = 1'b0;
        #1;
        n_tests++;
        if ({busy, wr_if.wr_valid_out, wr_if.wr_addr_out, wr_if.wr_data_out, fcnt, ovf, shortf, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got busy=%b valid=%b addr=%0d data=%h fcnt=%0d, expected all 0",
                     busy, wr_if.wr_valid_out, wr_if.wr_addr_out, wr_if.wr_data_out, fcnt);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int base, dbase, n;
        wr_t got;
        do_reset();
        base = wq.size(); dbase = done_cnt;
        pulse_arm();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL full_armed_busy: got %b expected 1", busy);
        end
        drive_pix(0, 0);
        n_tests++;
        if (wr_if.wr_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL full_blank_pixel: valid got %b expected 0", wr_if.wr_valid_out);
        end
        drive_pix(1, 0);
        n_tests++;
        if (wr_if.wr_valid_out !== 1'b1 || wr_if.wr_addr_out !== 6'd0 || wr_if.wr_data_out !== pix_data(1, 0)) begin
            n_fail++;
            $display("FAIL full_latency: got valid=%b addr=%0d data=%h, expected 1/0/%h",
                     wr_if.wr_valid_out, wr_if.wr_addr_out, wr_if.wr_data_out, pix_data(1, 0));
        end
        drive_frame(2);
        idle(5);
        n = wq.size() - base;
        n_tests++;
        if (n != 32) begin
            n_fail++; $display("FAIL full_count: got %0d writes expected 32", n);
        end
        for (int i = 0; i < 32 && i < n; i++) begin
            got = wq[base + i];
            n_tests++;
            if (got.addr !== AW'(i) || got.data !== pix_data(i % 8 + 1, i / 8)) begin
                n_fail++;
                $display("FAIL full_wr[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                         i, got.addr, got.data, i, pix_data(i % 8 + 1, i / 8));
            end
        end
        n_tests++;
        if (done_cnt - dbase != 1 || fcnt !== 16'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: got pulses=%0d fcnt=%0d busy=%b, expected 1/1/0",
                     done_cnt - dbase, fcnt, busy);
        end
    endtask

    task automatic test_decim();
        int base, dbase, n;
        wr_t got;
        do_reset();
        base = wq_d.size(); dbase = done_cnt_d;
        pulse_arm();
        drive_frame(0);
        idle(5);
        n = wq_d.size() - base;
        n_tests++;
        if (n != 8) begin
            n_fail++; $display("FAIL decim_count: got %0d writes expected 8", n);
        end
        for (int i = 0; i < 8 && i < n; i++) begin
            got = wq_d[base + i];
            n_tests++;
            if (got.addr !== AW'(i) || got.data !== pix_data((i % 4) * 2 + 1, (i / 4) * 2)) begin
                n_fail++;
                $display("FAIL decim_wr[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                         i, got.addr, got.data, i, pix_data((i % 4) * 2 + 1, (i / 4) * 2));
            end
        end
        n_tests++;
        if (done_cnt_d - dbase != 1 || fcnt_d !== 16'd1 || busy_d !== 1'b0) begin
            n_fail++;
            $display("FAIL decim_done: got pulses=%0d fcnt=%0d busy=%b, expected 1/1/0",
                     done_cnt_d - dbase, fcnt_d, busy_d);
        end
    endtask

    task automatic test_overflow();
        int base, n;
        do_reset();
        base = wq.size();
        pulse_arm();
        drive_pix(0, 0);
        set_ready(1'b0);
        drive_pix(1, 0);
        drive_pix(2, 0);
        drive_pix(3, 0);
        n_tests++;
        if (wr_if.wr_valid_out !== 1'b1 || wr_if.wr_addr_out !== 6'd0 || wr_if.wr_data_out !== pix_data(1, 0)) begin
            n_fail++;
            $display("FAIL ovf_hold: got valid=%b addr=%0d data=%h, expected 1/0/%h",
                     wr_if.wr_valid_out, wr_if.wr_addr_out, wr_if.wr_data_out, pix_data(1, 0));
        end
        set_ready(1'b1);
        drive_pix(4, 0);
        n_tests++;
        if (wr_if.wr_addr_out !== 6'd3 || wr_if.wr_data_out !== pix_data(4, 0) || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_next_addr: got addr=%0d data=%h ovf=%b, expected 3/%h/1",
                     wr_if.wr_addr_out, wr_if.wr_data_out, ovf, pix_data(4, 0));
        end
        drive_frame(5);
        idle(5);
        n = wq.size() - base;
        n_tests++;
        if (n != 30 || wq[base].addr !== 6'd0 || wq[base + 1].addr !== 6'd3 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_frame: got writes=%0d first=%0d second=%0d ovf=%b, expected 30/0/3/1",
                     n, wq[base].addr, wq[base + 1].addr, ovf);
        end
        pulse_arm();
        n_tests++;
        if (ovf !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ovf_clear_on_arm: got ovf=%b busy=%b, expected 0/1", ovf, busy);
        end
        pulse_abort();
    endtask

    task automatic test_short_frame();
        int base, dbase, n;
        do_reset();
        continuous_in = 1'b1;
        base = wq.size(); dbase = done_cnt;
        pulse_arm();
        drive_pix(0, 0);
        for (int i = 0; i < 10; i++) drive_pix(i % 8 + 1, i / 8);
        drive_pix(1, 0);
        n_tests++;
        if (shortf !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL short_flag: got short=%b busy=%b, expected 1/1", shortf, busy);
        end
        idle(3);
        n = wq.size() - base;
        n_tests++;
        if (n != 10 || done_cnt - dbase != 1 || fcnt !== 16'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL short_drain: got writes=%0d pulses=%0d fcnt=%0d busy=%b, expected 10/1/1/1",
                     n, done_cnt - dbase, fcnt, busy);
        end
        pulse_arm();
        n_tests++;
        if (shortf !== 1'b1) begin
            n_fail++; $display("FAIL arm_ignored_armed: got short=%b expected 1", shortf);
        end
        base = wq.size();
        drive_frame(0);
        idle(5);
        n = wq.size() - base;
        n_tests++;
        if (n != 32 || wq[base].addr !== 6'd0 || wq[base].data !== pix_data(1, 0)
            || wq[base + 31].addr !== 6'd31 || fcnt !== 16'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL short_rearm: got writes=%0d first=%0d last=%0d fcnt=%0d busy=%b, expected 32/0/31/2/1",
                     n, wq[base].addr, wq[base + 31].addr, fcnt, busy);
        end
        continuous_in = 1'b0;
        pulse_abort();
    endtask

    task automatic test_abort();
        int dbase;
        do_reset();
        set_ready(1'b0);
        dbase = done_cnt;
        pulse_arm();
        drive_pix(0, 0);
        drive_pix(1, 0);
        drive_pix(2, 0);
        n_tests++;
        if (wr_if.wr_valid_out !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre: got valid=%b busy=%b, expected 1/1", wr_if.wr_valid_out, busy);
        end
        abort_in = 1'b1;
        arm_in   = 1'b1;
        drive_pix(3, 0);
        abort_in = 1'b0;
        arm_in   = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || wr_if.wr_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got busy=%b valid=%b, expected 0/0", busy, wr_if.wr_valid_out);
        end
        set_ready(1'b1);
        idle(4);
        n_tests++;
        if (fcnt !== 16'd0 || done_cnt - dbase != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got fcnt=%0d pulses=%0d busy=%b, expected 0/0/0",
                     fcnt, done_cnt - dbase, busy);
        end
    endtask

    initial begin
        set_ready(1'b0);
        #1;
        test_reset();
        test_full_frame();
        test_decim();
        test_overflow();
        test_short_frame();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
